// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//
// Bundles every bus signal around alu_share_arbiter: the two requester
// handshakes, the response outputs and the ALU operand/result path.
//
// Handshake rules, in one place:
//   reqN_valid_i : requester N has an operation pending. Operands and ctrl
//                  must stay stable while valid is high and ready is low.
//                  Valid may be dropped before the grant.
//   reqN_ready_o : the operation is accepted in the cycle where valid and
//                  ready are both high. At most one ready is high per cycle,
//                  and only while the arbiter is idle.
//   rspN_valid_o : one-cycle pulse; rsp_data_o/rsp_zero_o carry the result.
//
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters plus the ALU)
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if;
    // Requester 0
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [31:0] req0_data1_i;
    logic [31:0] req0_data2_i;
    logic [2:0]  req0_ctrl_i;
    // Requester 1
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [31:0] req1_data1_i;
    logic [31:0] req1_data2_i;
    logic [2:0]  req1_ctrl_i;
    // Responses
    logic        rsp0_valid_o;
    logic        rsp1_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_zero_o;
    // ALU side
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_zero_i;

    modport slave (
        input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        input  alu_data_i, alu_zero_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_zero_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o
    );

    modport master (
        output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        output alu_data_i, alu_zero_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_zero_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares the execute-stage ALU between two requesters. One operation is
// granted at a time; its operands are held on the ALU inputs for one cycle
// (MUL_CYCLES cycles for MUL) and the result is returned to the winner as a
// one-cycle response pulse. No arithmetic is done here.
//
// Parameters:
//   MUL_CYCLES   cycles the ALU is held for MUL (ctrl 3'b101), 1..15
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> round-robin tie-break (requester 0 wins the
//                               first tie after reset)
//                  undefined -> fixed priority, requester 0 wins every tie
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   bus          alu_share_arbiter_if.slave (handshakes, response, ALU path)
//   busy_o       high in EXEC and RESP
//   dbg_state_o  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    alu_share_arbiter_if.slave        bus,
    output logic                      busy_o,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic        grant0, grant1;
    logic        tie_pick0;
    logic        win_q;
    logic [3:0]  cnt_q;
    logic [31:0] d1_q, d2_q, res_q;
    logic [2:0]  ctrl_q;
    logic        zero_q;
    logic [31:0] sel_data1, sel_data2;
    logic [2:0]  sel_ctrl;

`ifdef ALU_ARB_RR_EN
    // Id of the requester granted most recently; resets to 1 so that
    // requester 0 takes the first tie.
    logic last_grant_q;
    assign tie_pick0 = last_grant_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant_q <= grant1;
        end
    end
`else
    assign tie_pick0 = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and grant. Ready is combinational in IDLE so a request
    // is accepted in the same cycle it is seen; it is held low while reset
    // is asserted so every output reads 0 during reset.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_i) begin
                    if (bus.req0_valid_i && (!bus.req1_valid_i || tie_pick0)) begin
                        grant0 = 1'b1;
                    end else if (bus.req1_valid_i) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand select for the winner
    always_comb begin
        sel_data1 = bus.req0_data1_i;
        sel_data2 = bus.req0_data2_i;
        sel_ctrl  = bus.req0_ctrl_i;
        if (grant1) begin
            sel_data1 = bus.req1_data1_i;
            sel_data2 = bus.req1_data2_i;
            sel_ctrl  = bus.req1_ctrl_i;
        end
    end

    // Datapath: operand latch at acceptance, cycle counter, result capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            win_q  <= 1'b0;
            d1_q   <= '0;
            d2_q   <= '0;
            ctrl_q <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                win_q  <= grant1;
                d1_q   <= sel_data1;
                d2_q   <= sel_data2;
                ctrl_q <= sel_ctrl;
                cnt_q  <= (sel_ctrl == OP_MUL) ? MUL_LOAD : 4'd0;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Capture on the last EXEC cycle; holds after RESP.
            if (state_q == EXEC && cnt_q == 4'd0) begin
                res_q  <= bus.alu_data_i;
                zero_q <= bus.alu_zero_i;
            end
        end
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.rsp0_valid_o = (state_q == RESP) && !win_q;
    assign bus.rsp1_valid_o = (state_q == RESP) &&  win_q;
    assign bus.rsp_data_o   = res_q;
    assign bus.rsp_zero_o   = zero_q;
    assign bus.alu_data1_o  = d1_q;
    assign bus.alu_data2_o  = d2_q;
    assign bus.alu_ctrl_o   = ctrl_q;
    assign busy_o           = (state_q != IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter (MUL_CYCLES = 3). A behavioural ALU
// answers combinationally from the arbiter's ALU outputs; undefined opcodes
// return 32'hDEADBEEF so pass-through can be seen. Inputs change on the
// falling edge, outputs are sampled 1 ns after it.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       busy_o;
    logic [1:0] dbg_state_o;
    int         checks = 0;
    int         errors = 0;

    alu_share_arbiter_if bus();

    alu_share_arbiter #(.MUL_CYCLES(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Behavioural ALU
    always_comb begin
        case (bus.alu_ctrl_o)
            3'b000:  bus.alu_data_i = bus.alu_data1_o + bus.alu_data2_o;
            3'b001:  bus.alu_data_i = bus.alu_data1_o - bus.alu_data2_o;
            3'b010:  bus.alu_data_i = bus.alu_data1_o & bus.alu_data2_o;
            3'b011:  bus.alu_data_i = bus.alu_data1_o | bus.alu_data2_o;
            3'b101:  bus.alu_data_i = bus.alu_data1_o * bus.alu_data2_o;
            default: bus.alu_data_i = 32'hDEADBEEF;
        endcase
        bus.alu_zero_i = (bus.alu_data_i == 32'd0);
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic drive_req0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req0_data1_i = a;
        bus.req0_data2_i = b;
        bus.req0_ctrl_i  = op;
        bus.req0_valid_i = 1'b1;
    endtask

    task automatic drive_req1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req1_data1_i = a;
        bus.req1_data2_i = b;
        bus.req1_ctrl_i  = op;
        bus.req1_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        drive_req0(32'd1, 32'd1, 3'b000);
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (bus.req0_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b required 0", bus.req0_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state_o); end
        checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b required 00", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
        checks++; if (bus.rsp_data_o !== 32'd0 || bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b required 0/0", bus.rsp_data_o, bus.rsp_zero_o); end
        checks++; if (bus.alu_data1_o !== 32'd0 || bus.alu_data2_o !== 32'd0 || bus.alu_ctrl_o !== 3'd0) begin errors++; $display("FAIL reset_alu_out: got %h %h %h required 0 0 0", bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o); end
        bus.req0_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy %b required 0", busy_o); end
    endtask

    task automatic test_req0_add();
        @(negedge clk_i);
        drive_req0(32'd5, 32'd7, 3'b000);
        #1;
        checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b10) begin errors++; $display("FAIL add_ready: got %b required 10", {bus.req0_ready_o, bus.req1_ready_o}); end
        @(negedge clk_i);
        bus.req0_valid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b1 || bus.rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL add_exec: got busy %b rsp0 %b required 1 0", busy_o, bus.rsp0_valid_o); end
        checks++; if (bus.alu_data1_o !== 32'd5 || bus.alu_data2_o !== 32'd7) begin errors++; $display("FAIL add_alu_ops: got %h %h required 5 7", bus.alu_data1_o, bus.alu_data2_o); end
        @(negedge clk_i);
        #1;
        checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b10) begin errors++; $display("FAIL add_rsp: got %b required 10", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
        checks++; if (bus.rsp_data_o !== 32'd12 || bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL add_data: got %h/%b required c/0", bus.rsp_data_o, bus.rsp_zero_o); end
        @(negedge clk_i);
        #1;
        checks++; if (bus.rsp0_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL add_done: got rsp0 %b busy %b required 0 0", bus.rsp0_valid_o, busy_o); end
        checks++; if (bus.rsp_data_o !== 32'd12) begin errors++; $display("FAIL add_hold: got %h required c", bus.rsp_data_o); end
    endtask

    task automatic test_req1_sub();
        @(negedge clk_i);
        drive_req1(32'd9, 32'd9, 3'b001);
        #1;
        checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b01) begin errors++; $display("FAIL sub_ready: got %b required 01", {bus.req0_ready_o, bus.req1_ready_o}); end
        @(negedge clk_i);
        bus.req1_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b01) begin errors++; $display("FAIL sub_rsp: got %b required 01", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
        checks++; if (bus.rsp_data_o !== 32'd0 || bus.rsp_zero_o !== 1'b1) begin errors++; $display("FAIL sub_data: got %h/%b required 0/1", bus.rsp_data_o, bus.rsp_zero_o); end
    endtask

    task automatic test_both_valid();
        int exp_id[4];
        int waited;
        int got;
`ifdef ALU_ARB_RR_EN
        exp_id = '{0, 1, 0, 1};
`else
        exp_id = '{0, 0, 0, 0};
`endif
        @(negedge clk_i);
        drive_req0(32'h0000_00F0, 32'h0000_000F, 3'b011);
        drive_req1(32'h0000_00F0, 32'h0000_003C, 3'b010);
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            #1;
            while (!bus.req0_ready_o && !bus.req1_ready_o && waited < 8) begin
                @(negedge clk_i);
                #1;
                waited++;
            end
            checks++; if (waited != 0) begin errors++; $display("FAIL both_gap%0d: got %0d extra cycles required 0", i, waited); end
            checks++; if (bus.req0_ready_o && bus.req1_ready_o) begin errors++; $display("FAIL both_dual_ready%0d: got 11 required one-hot", i); end
            got = bus.req1_ready_o ? 1 : (bus.req0_ready_o ? 0 : -1);
            checks++; if (got != exp_id[i]) begin errors++; $display("FAIL both_grant%0d: got %0d required %0d", i, got, exp_id[i]); end
            @(negedge clk_i);
            @(negedge clk_i);
            #1;
            checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== ((exp_id[i] == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL both_rsp%0d: got %b required winner %0d", i, {bus.rsp0_valid_o, bus.rsp1_valid_o}, exp_id[i]); end
            checks++; if (bus.rsp_data_o !== ((exp_id[i] == 1) ? 32'h30 : 32'hFF)) begin errors++; $display("FAIL both_data%0d: got %h required %h", i, bus.rsp_data_o, (exp_id[i] == 1) ? 32'h30 : 32'hFF); end
            if (i == 3) begin
                bus.req0_valid_i = 1'b0;
                bus.req1_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        #1;
        checks++; if (bus.req0_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL both_quiet: got ready0 %b busy %b required 0 0", bus.req0_ready_o, busy_o); end
    endtask

    task automatic test_mul();
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk_i);
        drive_req0(32'h0001_0000, 32'h0000_0010, 3'b101);
        #1;
        checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL mul_ready: got %b required 1", bus.req0_ready_o); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (k == 1) bus.req0_valid_i = 1'b0;
            #1;
            if (busy_o === 1'b1) busy_cnt++;
            if (k <= 4) begin
                checks++; if (bus.alu_data1_o !== 32'h0001_0000 || bus.alu_data2_o !== 32'h10 || bus.alu_ctrl_o !== 3'b101) begin errors++; $display("FAIL mul_alu_hold%0d: got %h %h %h required 10000 10 5", k, bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o); end
            end
            checks++; if (bus.rsp0_valid_o !== (k == 4)) begin errors++; $display("FAIL mul_rsp_t%0d: got %b required %b", k, bus.rsp0_valid_o, (k == 4)); end
            if (k == 4) begin
                checks++; if (bus.rsp_data_o !== 32'h0010_0000 || bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL mul_data: got %h/%b required 100000/0", bus.rsp_data_o, bus.rsp_zero_o); end
            end
        end
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL mul_busy_len: got %0d required 4", busy_cnt); end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk_i);
        drive_req0(32'd2, 32'd3, 3'b101);
        @(negedge clk_i);
        bus.req0_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || dbg_state_o !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got busy %b state %0d required 0 0", busy_o, dbg_state_o); end
        checks++; if (bus.alu_data1_o !== 32'd0 || bus.alu_ctrl_o !== 3'd0) begin errors++; $display("FAIL rst_mid_alu: got %h %h required 0 0", bus.alu_data1_o, bus.alu_ctrl_o); end
        checks++; if (bus.rsp_data_o !== 32'd0) begin errors++; $display("FAIL rst_mid_rsp_data: got %h required 0", bus.rsp_data_o); end
        drive_req0(32'd1, 32'd2, 3'b000);
        #1;
        checks++; if (bus.req0_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b required 0", bus.req0_ready_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            checks++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp%0d: got %b%b required 00", k, bus.rsp0_valid_o, bus.rsp1_valid_o); end
        end
        rst_i = 1'b1;
        #1;
        checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL rst_rel_ready: got %b required 1", bus.req0_ready_o); end
        @(negedge clk_i);
        bus.req0_valid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b1 || bus.alu_data1_o !== 32'd1) begin errors++; $display("FAIL rst_rel_accept: got busy %b data1 %h required 1 1", busy_o, bus.alu_data1_o); end
        @(negedge clk_i);
        #1;
        checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp_data_o !== 32'd3) begin errors++; $display("FAIL rst_rel_rsp: got %b/%h required 1/3", bus.rsp0_valid_o, bus.rsp_data_o); end
    endtask

    task automatic test_undef_opcode();
        @(negedge clk_i);
        drive_req1(32'd3, 32'd4, 3'b111);
        #1;
        checks++; if (bus.req1_ready_o !== 1'b1) begin errors++; $display("FAIL op7_ready: got %b required 1", bus.req1_ready_o); end
        @(negedge clk_i);
        bus.req1_valid_i = 1'b0;
        #1;
        checks++; if (bus.alu_ctrl_o !== 3'b111) begin errors++; $display("FAIL op7_ctrl: got %b required 111", bus.alu_ctrl_o); end
        @(negedge clk_i);
        #1;
        checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b01) begin errors++; $display("FAIL op7_rsp: got %b required 01", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
        checks++; if (bus.rsp_data_o !== 32'hDEADBEEF || bus.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL op7_data: got %h/%b required deadbeef/0", bus.rsp_data_o, bus.rsp_zero_o); end
        @(negedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL op7_done: got busy %b required 0", busy_o); end
    endtask

    initial begin
        bus.req0_valid_i = 1'b0;
        bus.req0_data1_i = '0;
        bus.req0_data2_i = '0;
        bus.req0_ctrl_i  = '0;
        bus.req1_valid_i = 1'b0;
        bus.req1_data1_i = '0;
        bus.req1_data2_i = '0;
        bus.req1_ctrl_i  = '0;
        test_reset();
        test_req0_add();
        test_req1_sub();
        test_both_valid();
        test_mul();
        test_reset_mid_mul();
        test_undef_opcode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single ALU of the execute stage between two requesters (pipeline issue and the multi-cycle divide/address helper). It runs a handshake per requester, grants one operation at a time, holds the operands stable on the ALU inputs for the required number of cycles (MUL occupies the ALU for several cycles), and returns the result to the winning requester. It sits between the requesters and the ALU and contains no arithmetic of its own.

## Interface
- MUL_CYCLES, 3, cycles the ALU is held for a MUL (ctrl 3'b101); legal range 1..15
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- req0_valid_i / req1_valid_i  in  1  requester n has an operation pending
- req0_ready_o / req1_ready_o  out  1  operation of requester n accepted this cycle
- req0_data1_i, req0_data2_i / req1_...  in  32  operands
- req0_ctrl_i / req1_ctrl_i  in  3  ALU opcode: ADD 000, SUB 001, AND 010, OR 011, MUL 101
- rsp0_valid_o / rsp1_valid_o  out  1  one-cycle pulse: result for requester n
- rsp_data_o  out  32  result; valid only with a rsp pulse
- rsp_zero_o  out  1  zero flag of the result
- alu_data1_o, alu_data2_o  out  32  operands to the ALU
- alu_ctrl_o  out  3  opcode to the ALU
- alu_data_i  in  32  ALU result
- alu_zero_i  in  1  ALU zero flag
- busy_o  out  1  high in EXEC and RESP

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any valid is high, pick a winner and assert its ready combinationally in the same cycle. Latch data1/data2/ctrl and the winner id, then go to EXEC. Load cnt with MUL_CYCLES-1 for MUL, otherwise 0. With no valid, stay in IDLE.
- Arbitration: one requester valid means it wins. Both valid means round-robin: the requester not granted last wins. last_grant resets to 1, so requester 0 wins the first tie.
- EXEC: alu_*_o driven from the latched registers. When cnt==0, capture alu_data_i/alu_zero_i into result registers and go to RESP; otherwise decrement cnt.
- RESP: pulse rspN_valid_o for the latched winner only; rsp_data_o/rsp_zero_o hold the captured values. Return to IDLE.
- Undefined opcodes (100, 110, 111) are single-cycle and pass through unmodified; the result is whatever the ALU returns.
- A requester must keep its operands stable while valid is high and ready is low. Dropping valid before the grant is legal.
- Reset (asynchronous, any state) drives the following:
  - state to IDLE, in-flight op dropped, no rsp pulse;
  - all outputs to 0, last_grant to 1, cnt to 0.

## Timing
- Accept at cycle T (ready high).
- Non-MUL: EXEC at T+1, rsp pulse at T+2. Latency 2.
- MUL: EXEC T+1..T+MUL_CYCLES, rsp pulse at T+MUL_CYCLES+1.
- Next acceptance is no earlier than the cycle after RESP. Peak throughput is one op per 3 cycles.
- ready is never asserted outside IDLE, and never to both requesters in the same cycle.
- alu_*_o are registered; they change only at acceptance and hold until the next acceptance.
- rsp_data_o and rsp_zero_o are registered and hold their last value after RESP.

## Configuration
- ALU_ARB_RR_EN defined: round-robin tie-break as above.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins a tie. The last_grant register is not implemented.
- The single-requester case is identical in both builds.

## Test plan
- Req0 only: ADD 5+7 -> ready0 at T, rsp0_valid at T+2, data 12, zero 0. rsp1 and ready1 stay low.
- Req1 only: SUB 9-9 -> rsp1 at T+2, data 0, zero 1.
- Both valid continuously: req0 OR, req1 AND.
  - With ALU_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without ALU_ARB_RR_EN: 0 wins every tie and req1 starves.
- MUL 0x10000*0x10 with MUL_CYCLES=3 -> busy_o for 4 cycles, rsp at T+4, data 0x100000. alu_*_o stable throughout.
- Assert rst_i low during MUL EXEC -> asynchronous return to IDLE, all outputs 0, no rsp pulse. After release, a pending req0 is accepted on the first clock.
- Opcode 3'b111 -> single-cycle, rsp at T+2 with the ALU's output passed through.
